// File: rtl/uart_pkg.sv
// Shared UART-path definitions: case-mapping mode encodings, ASCII letter
// bounds and the byte case-mapping function used by several stages.
package uart_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_UPPER = 2'b01,
    MODE_LOWER = 2'b10,
    MODE_SWAP  = 2'b11
  } mode_e;

  localparam logic [7:0] ASCII_UC_A        = 8'h41;
  localparam logic [7:0] ASCII_UC_Z        = 8'h5A;
  localparam logic [7:0] ASCII_LC_A        = 8'h61;
  localparam logic [7:0] ASCII_LC_Z        = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

  // Only the 26 ASCII letters in each case move; everything else is untouched.
  function automatic logic [7:0] case_map(input logic [7:0] b, input mode_e mode);
    logic       is_upper;
    logic       is_lower;
    logic [7:0] r;
    is_upper = (b >= ASCII_UC_A) && (b <= ASCII_UC_Z);
    is_lower = (b >= ASCII_LC_A) && (b <= ASCII_LC_Z);
    r        = b;
    case (mode)
      MODE_PASS:  r = b;
      MODE_UPPER: if (is_lower) r = b - ASCII_CASE_OFFSET; else r = b;
      MODE_LOWER: if (is_upper) r = b + ASCII_CASE_OFFSET; else r = b;
      MODE_SWAP: begin
        if (is_lower)      r = b - ASCII_CASE_OFFSET;
        else if (is_upper) r = b + ASCII_CASE_OFFSET;
        else               r = b;
      end
      default:    r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and full/empty flags.
// Callers must not push while full unless they pop in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;

  assign o_rdata = mem[rd_ptr_q];
  assign o_count = count_q;
  assign o_empty = empty_q;
  assign o_full  = full_q;

  // Storage write; when full with a concurrent pop, wr_ptr equals rd_ptr and
  // the head is read combinationally before this edge overwrites it.
  always_ff @(posedge i_clk) begin
    if (i_push) mem[wr_ptr_q] <= i_wdata;
  end

  // Pointer wrap is implicit because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) wr_ptr_d = wr_ptr_q + AW'(1); else wr_ptr_d = wr_ptr_q;
    if (i_pop)  rd_ptr_d = rd_ptr_q + AW'(1); else rd_ptr_d = rd_ptr_q;
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == CW'(0));
    full_d  = (count_d == CW'(DEPTH));
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

endmodule

// File: rtl/case_convert_buffer.sv
// Buffers receiver byte strobes in a FIFO, case-maps the head as it is popped
// into the output register, and hands bytes to the transmitter via valid/ready.
module case_convert_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [7:0]              i_data,
  input  logic                    i_valid,
  input  logic [1:0]              i_mode,
  input  logic                    i_clr_overflow,
  output logic [7:0]              o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_empty,
  output logic                    o_full,
  output logic                    o_overflow
);
  logic [7:0] head;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       push;
  logic       drop;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       overflow_q, overflow_d;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign pop  = ~fifo_empty & (~valid_q | i_ready);
  assign push = i_valid & (~fifo_full | pop);
  assign drop = i_valid & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_wdata (i_data),
    .i_pop   (pop),
    .o_rdata (head),
    .o_count (o_count),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  assign o_empty    = fifo_empty;
  assign o_full     = fifo_full;
  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_overflow = overflow_q;

  // Output register load/release and sticky overflow; a drop beats a clear.
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    if (pop) begin
      data_d  = case_map(head, mode_e'(i_mode));
      valid_d = 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (drop)                overflow_d = 1'b1;
    else if (i_clr_overflow) overflow_d = 1'b0;
    else                     overflow_d = overflow_q;
  end

  // Output and status registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
